imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Owns the single instruction-memory port and shares it between three requesters: the IFU fetch path, the boot loader stream that fills instruction memory before the core runs, and a debug read port. It sequences the core's life cycle (boot load, then run) and stalls the IFU whenever it does not hold the port. It sits between the IFU and the instruction memory instance, replacing the IFU's direct memory connection.

## Interface

- BOOT_ON_RESET, 1, 1: reset enters BOOT (loader owns memory); 0: reset enters RUN directly (memory preloaded by bench)
- NOP_INSTR, 32'h0000_0000, instruction word driven to the IFU while fetch is stalled
- CNT_W, 16, width of the load-word counter

- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- fetch_addr  in  32  IFU byte PC
- fetch_instr  out  32  instruction to IFU
- fetch_stall  out  1  IFU must hold its PC this cycle
- core_run  out  1  1 in RUN state
- ld_valid  in  1  loader word valid
- ld_ready  out  1  arbiter accepts a loader word
- ld_addr  in  32  loader byte address
- ld_data  in  32  loader word
- ld_last  in  1  final word of the image
- ld_err  out  1  sticky: a misaligned loader address was accepted
- load_count  out  CNT_W  words written since the last BOOT entry, saturating
- reload  in  1  in RUN: return to BOOT
- dbg_req  in  1  debug read request, held until dbg_ack
- dbg_addr  in  32  debug byte address
- dbg_ack  out  1  one-cycle pulse, dbg_rdata valid
- dbg_rdata  out  32  registered debug read data
- mem_addr  out  32  word-aligned byte address to memory
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  combinational memory read data

## Operation

- States: BOOT, RUN. Reset: BOOT if BOOT_ON_RESET else RUN. Memory contents are never touched by reset.
- BOOT: ld_ready=1, fetch_stall=1, core_run=0, fetch_instr=NOP_INSTR. dbg_req is ignored in BOOT (no ack).
- Loader handshake: a word transfers when ld_valid & ld_ready at posedge. Same cycle: mem_we=1, mem_addr={ld_addr[31:2],2'b00}, mem_wdata=ld_data. load_count increments, saturating at all-ones. ld_addr[1:0]!=0 on a transfer sets ld_err; the aligned write still happens.
- Transfer with ld_last=1: state goes to RUN after that edge.
- RUN: ld_ready=0, mem_we=0. Default grant is fetch: mem_addr={fetch_addr[31:2],2'b00}, fetch_instr=mem_rdata, fetch_stall=0.
- Debug grant in RUN happens when dbg_req=1 and dbg_ack=0 (cooldown).
  - mem_addr={dbg_addr[31:2],2'b00}, fetch_stall=1, fetch_instr=NOP_INSTR.
  - mem_rdata is captured into dbg_rdata at the edge, and dbg_ack=1 for the next cycle.
- Cooldown: the cycle with dbg_ack=1 is always a fetch cycle. Debug therefore gets at most 1 of every 2 cycles and fetch is never starved.
- reload=1 in RUN: state goes to BOOT at the edge. On that edge load_count clears to 0; ld_err is not cleared (reset only). A debug grant in the same cycle still completes, so dbg_ack pulses in the first BOOT cycle.
- reload in BOOT is ignored.

## Timing

- Reset values: state per BOOT_ON_RESET, dbg_ack=0, dbg_rdata=0, ld_err=0, load_count=0.
  - With BOOT_ON_RESET=1: fetch_stall=1, core_run=0, ld_ready=1.
  - With BOOT_ON_RESET=0: fetch_stall=0, core_run=1, ld_ready=0.
- fetch_stall, fetch_instr, mem_addr, mem_we, mem_wdata and ld_ready are combinational from state, dbg_req/dbg_ack and the inputs. There is no path from mem_rdata to any control output.
- Fetch latency: 0 cycles (single-cycle memory read).
- Loader throughput: 1 word per cycle.
- Debug latency: request granted in cycle N; dbg_ack and dbg_rdata in cycle N+1. Back-to-back held requests are granted in N, N+2, N+4, ...
- core_run rises in the first cycle after the ld_last transfer. That cycle is a fetch cycle unless dbg_req is high, in which case debug wins.
- Reset asserted mid-transfer or mid-debug: the pending dbg_ack is dropped and the state is reinitialised. A write in the reset cycle is suppressed (mem_we=0 while reset=1).

## Test plan

- Boot load, BOOT_ON_RESET=1: stream 3 words to byte addresses 0, 4, 8 (last on the third).
  - Required: mem_we on exactly 3 cycles and load_count=3.
  - core_run=1 the cycle after, with fetch_stall 1→0.
  - Fetch at PC 0, 4, 8 returns the 3 words.
- Loader stall: ld_valid toggles 1,0,1 and ld_last=1 on the second valid word.
  - Required: load_count=2 and RUN entered only after the second transfer.
- Misaligned load: ld_addr=32'h6, data=32'hDEADBEEF.
  - Required: ld_err=1, and the word is written at 4, so a fetch at PC 4 returns DEADBEEF.
  - ld_err persists after reload and clears only on reset.
- Debug in RUN: dbg_req held with dbg_addr=8.
  - Required: fetch_stall and NOP_INSTR in cycle N; dbg_ack=1 with dbg_rdata equal to word 2 in N+1, and fetch unstalled in N+1.
  - With dbg_req held for 6 cycles, the grant/stall pattern is 1,0,1,0,1,0.
- Reload with a simultaneous debug grant:
  - Required: dbg_ack pulses in the first BOOT cycle, load_count=0, ld_ready=1, fetch_stall=1.
- BOOT_ON_RESET=0 with preloaded memory: reset.
  - Required: core_run=1 in the first cycle and fetch at PC 0 returns word 0.
  - Reset mid-debug-grant drops the ack (dbg_ack stays 0).

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Instruction-memory port owner: sequences boot load then run, and shares the
// single port between the loader (BOOT), the IFU fetch path and debug reads (RUN).
module imem_port_arbiter #(
  parameter bit          BOOT_ON_RESET = 1'b1,
  parameter logic [31:0] NOP_INSTR     = 32'h0000_0000,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      fetch_addr,
  output logic [31:0]      fetch_instr,
  output logic             fetch_stall,
  output logic             core_run,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             ld_err,
  output logic [CNT_W-1:0] load_count,
  input  logic             reload,
  input  logic             dbg_req,
  input  logic [31:0]      dbg_addr,
  output logic             dbg_ack,
  output logic [31:0]      dbg_rdata,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t state, state_nxt;
  logic   dbg_grant;
  logic   ld_fire;
  logic   unused_addr_bits;

  assign unused_addr_bits = ^{fetch_addr[1:0], dbg_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= BOOT_ON_RESET ? BOOT : RUN;
    else       state <= state_nxt;
  end

  // Port steering is purely from state, dbg_req/dbg_ack and addresses; mem_rdata
  // only ever reaches data outputs.
  always_comb begin
    state_nxt   = state;
    ld_ready    = 1'b0;
    ld_fire     = 1'b0;
    core_run    = 1'b0;
    dbg_grant   = 1'b0;
    fetch_stall = 1'b1;
    fetch_instr = NOP_INSTR;
    mem_addr    = {fetch_addr[31:2], 2'b00};
    mem_we      = 1'b0;
    mem_wdata   = ld_data;
    case (state)
      BOOT: begin
        ld_ready = 1'b1;
        ld_fire  = ld_valid;
        mem_addr = {ld_addr[31:2], 2'b00};
        mem_we   = ld_valid & ~reset;
        if (ld_valid && ld_last) state_nxt = RUN;
      end
      RUN: begin
        core_run = 1'b1;
        // The ack cycle is always handed back to fetch so it is never starved.
        dbg_grant = dbg_req & ~dbg_ack;
        if (dbg_grant) begin
          mem_addr = {dbg_addr[31:2], 2'b00};
        end else begin
          fetch_stall = 1'b0;
          fetch_instr = mem_rdata;
        end
        if (reload) state_nxt = BOOT;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_ack    <= 1'b0;
      dbg_rdata  <= 32'h0;
      ld_err     <= 1'b0;
      load_count <= '0;
    end else begin
      dbg_ack <= dbg_grant;
      if (dbg_grant) dbg_rdata <= mem_rdata;
      if (ld_fire) begin
        if (load_count != '1) load_count <= load_count + CNT_W'(1);
        if (ld_addr[1:0] != 2'b00) ld_err <= 1'b1;
      end
      // ld_err survives a reload; only reset clears it.
      if (state == RUN && reload) load_count <= '0;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench: one arbiter booting via the loader, one starting in RUN
// against a preloaded memory model.
module tb_imem_port_arbiter;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  logic        a_rst, a_fetch_stall, a_core_run, a_ld_valid, a_ld_ready, a_ld_last;
  logic        a_ld_err, a_reload, a_dbg_req, a_dbg_ack, a_mem_we;
  logic [31:0] a_fetch_addr, a_fetch_instr, a_ld_addr, a_ld_data, a_dbg_addr;
  logic [31:0] a_dbg_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [15:0] a_load_count;

  logic        b_rst, b_fetch_stall, b_core_run, b_ld_valid, b_ld_ready, b_ld_last;
  logic        b_ld_err, b_reload, b_dbg_req, b_dbg_ack, b_mem_we;
  logic [31:0] b_fetch_addr, b_fetch_instr, b_ld_addr, b_ld_data, b_dbg_addr;
  logic [31:0] b_dbg_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [15:0] b_load_count;

  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  int          we_cnt_a = 0;
  logic [31:0] wv [0:2];

  imem_port_arbiter #(.BOOT_ON_RESET(1'b1), .NOP_INSTR(32'h0), .CNT_W(16)) dut_a (
    .clk(clk), .reset(a_rst),
    .fetch_addr(a_fetch_addr), .fetch_instr(a_fetch_instr), .fetch_stall(a_fetch_stall),
    .core_run(a_core_run),
    .ld_valid(a_ld_valid), .ld_ready(a_ld_ready), .ld_addr(a_ld_addr), .ld_data(a_ld_data),
    .ld_last(a_ld_last), .ld_err(a_ld_err), .load_count(a_load_count), .reload(a_reload),
    .dbg_req(a_dbg_req), .dbg_addr(a_dbg_addr), .dbg_ack(a_dbg_ack), .dbg_rdata(a_dbg_rdata),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  imem_port_arbiter #(.BOOT_ON_RESET(1'b0), .NOP_INSTR(32'h0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(b_rst),
    .fetch_addr(b_fetch_addr), .fetch_instr(b_fetch_instr), .fetch_stall(b_fetch_stall),
    .core_run(b_core_run),
    .ld_valid(b_ld_valid), .ld_ready(b_ld_ready), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
    .ld_last(b_ld_last), .ld_err(b_ld_err), .load_count(b_load_count), .reload(b_reload),
    .dbg_req(b_dbg_req), .dbg_addr(b_dbg_addr), .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Single-cycle memory models: combinational read, write on posedge.
  assign a_mem_rdata = mem_a[a_mem_addr[7:2]];
  assign b_mem_rdata = mem_b[b_mem_addr[7:2]];

  always @(posedge clk) begin
    if (a_mem_we) begin
      mem_a[a_mem_addr[7:2]] <= a_mem_wdata;
      we_cnt_a <= we_cnt_a + 1;
    end
    if (b_mem_we) mem_b[b_mem_addr[7:2]] <= b_mem_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    wv[0] = 32'h1111_1111;
    wv[1] = 32'h2222_2222;
    wv[2] = 32'h3333_3333;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'hB000_0000 + i;
    end
    a_rst = 1; a_fetch_addr = 0; a_ld_valid = 0; a_ld_addr = 0; a_ld_data = 0;
    a_ld_last = 0; a_reload = 0; a_dbg_req = 0; a_dbg_addr = 0;
    b_rst = 1; b_fetch_addr = 0; b_ld_valid = 0; b_ld_addr = 0; b_ld_data = 0;
    b_ld_last = 0; b_reload = 0; b_dbg_req = 0; b_dbg_addr = 0;
    tick; tick;

    // Reset state, BOOT_ON_RESET=1
    a_rst = 0;
    #1;
    chk("a_rst_core_run", a_core_run, 0);
    chk("a_rst_stall", a_fetch_stall, 1);
    chk("a_rst_ld_ready", a_ld_ready, 1);
    chk("a_rst_instr", a_fetch_instr, 0);
    chk("a_rst_dbg_ack", a_dbg_ack, 0);
    chk("a_rst_dbg_rdata", a_dbg_rdata, 0);
    chk("a_rst_ld_err", a_ld_err, 0);
    chk("a_rst_count", a_load_count, 0);

    // Debug ignored in BOOT
    a_dbg_req = 1;
    tick;
    chk("boot_dbg_ignored", a_dbg_ack, 0);
    a_dbg_req = 0;

    // Boot load of 3 words
    for (int i = 0; i < 3; i++) begin
      a_ld_valid = 1; a_ld_addr = i * 4; a_ld_data = wv[i]; a_ld_last = (i == 2);
      #1;
      chk("load_we", a_mem_we, 1);
      chk("load_addr", a_mem_addr, i * 4);
      chk("load_stall", a_fetch_stall, 1);
      tick;
    end
    a_ld_valid = 0; a_ld_last = 0;
    #1;
    chk("boot_done_run", a_core_run, 1);
    chk("boot_done_stall", a_fetch_stall, 0);
    chk("boot_done_ready", a_ld_ready, 0);
    chk("boot_done_count", a_load_count, 3);
    chk("boot_we_cycles", we_cnt_a, 3);
    for (int i = 0; i < 3; i++) begin
      a_fetch_addr = i * 4;
      #1;
      chk("fetch_word", a_fetch_instr, wv[i]);
      chk("fetch_no_we", a_mem_we, 0);
    end
    a_fetch_addr = 0;

    // Held debug request: grant every other cycle
    a_dbg_req = 1; a_dbg_addr = 8;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("dbg_stall_pattern", a_fetch_stall, (i % 2 == 0));
      chk("dbg_ack_pattern", a_dbg_ack, (i % 2 == 1));
      if (i == 0) begin
        chk("dbg_grant_nop", a_fetch_instr, 0);
        chk("dbg_grant_addr", a_mem_addr, 8);
      end
      if (i == 1) begin
        chk("dbg_rdata", a_dbg_rdata, wv[2]);
        chk("dbg_ack_fetch", a_fetch_instr, wv[0]);
      end
      tick;
    end
    a_dbg_req = 0;

    // Reload with a simultaneous debug grant
    a_dbg_req = 1; a_dbg_addr = 4; a_reload = 1;
    #1;
    chk("reload_grant_stall", a_fetch_stall, 1);
    tick;
    a_dbg_req = 0; a_reload = 0;
    #1;
    chk("reload_dbg_ack", a_dbg_ack, 1);
    chk("reload_dbg_rdata", a_dbg_rdata, wv[1]);
    chk("reload_core_run", a_core_run, 0);
    chk("reload_count", a_load_count, 0);
    chk("reload_ld_ready", a_ld_ready, 1);
    chk("reload_stall", a_fetch_stall, 1);
    tick;
    chk("reload_ack_pulse", a_dbg_ack, 0);

    // Loader stall 1,0,1 with misaligned last word
    a_ld_valid = 1; a_ld_addr = 12; a_ld_data = 32'h4444_4444; a_ld_last = 0;
    tick;
    a_ld_valid = 0; a_ld_last = 1;
    #1;
    chk("stall_count1", a_load_count, 1);
    chk("stall_no_err", a_ld_err, 0);
    chk("stall_idle_we", a_mem_we, 0);
    tick;
    chk("stall_still_boot", a_core_run, 0);
    a_ld_valid = 1; a_ld_addr = 32'h6; a_ld_data = 32'hDEAD_BEEF; a_ld_last = 1;
    #1;
    chk("mis_addr", a_mem_addr, 4);
    chk("mis_we", a_mem_we, 1);
    tick;
    a_ld_valid = 0; a_ld_last = 0;
    #1;
    chk("stall_count2", a_load_count, 2);
    chk("stall_run", a_core_run, 1);
    chk("mis_err", a_ld_err, 1);
    a_fetch_addr = 4;
    #1;
    chk("mis_fetch4", a_fetch_instr, 32'hDEAD_BEEF);
    a_fetch_addr = 12;
    #1;
    chk("fetch12", a_fetch_instr, 32'h4444_4444);

    // ld_err survives reload
    a_reload = 1;
    tick;
    a_reload = 0;
    #1;
    chk("err_reload_boot", a_core_run, 0);
    chk("err_after_reload", a_ld_err, 1);
    chk("count_after_reload", a_load_count, 0);

    // Reset suppresses a write and clears ld_err
    a_ld_valid = 1; a_ld_addr = 0; a_ld_data = 32'h5555_5555; a_rst = 1;
    #1;
    chk("rst_we_suppressed", a_mem_we, 0);
    tick;
    a_rst = 0; a_ld_valid = 0;
    #1;
    chk("rst_err_clear", a_ld_err, 0);
    chk("rst_count_clear", a_load_count, 0);
    chk("rst_boot", a_core_run, 0);
    chk("rst_mem_kept", mem_a[0], wv[0]);

    // BOOT_ON_RESET=0 with preloaded memory
    b_rst = 0;
    #1;
    chk("b_rst_core_run", b_core_run, 1);
    chk("b_rst_stall", b_fetch_stall, 0);
    chk("b_rst_ld_ready", b_ld_ready, 0);
    chk("b_rst_dbg_ack", b_dbg_ack, 0);
    chk("b_rst_dbg_rdata", b_dbg_rdata, 0);
    chk("b_fetch0", b_fetch_instr, 32'hB000_0000);
    b_fetch_addr = 8;
    #1;
    chk("b_fetch8", b_fetch_instr, 32'hB000_0002);

    // Reset during a debug grant drops the ack
    b_dbg_req = 1; b_dbg_addr = 8;
    #1;
    chk("b_grant_stall", b_fetch_stall, 1);
    b_rst = 1;
    tick;
    b_rst = 0; b_dbg_req = 0;
    #1;
    chk("b_rst_drop_ack", b_dbg_ack, 0);
    chk("b_rst_drop_rdata", b_dbg_rdata, 0);
    chk("b_rst_run_again", b_core_run, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
